// File: rtl/line_xfer_sequencer.sv
// Line transfer sequencer: turns a cache line writeback and/or fill into four
// gated word accesses to banked memory, returning fill words with a fixed read latency.
module line_xfer_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_wb,
    input  logic              req_fill,
    input  logic [ADDR_W-4:0] wb_line_addr,
    input  logic [ADDR_W-4:0] fill_line_addr,
    output logic [1:0]        cache_rd_offset,
    input  logic [DATA_W-1:0] cache_rd_data,
    output logic              fill_valid,
    output logic [1:0]        fill_offset,
    output logic [DATA_W-1:0] fill_data,
    output logic              xfer_busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_wr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_stall,
    input  logic [3:0]        mem_busy,
    input  logic              mem_err
);

    localparam int LINE_W = ADDR_W - 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WB    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [1:0]              wcnt_r;
    logic [1:0]              rcnt_r;
    logic [LINE_W-1:0]       wb_line_r;
    logic [LINE_W-1:0]       fill_line_r;
    logic                    do_fill_r;
    logic                    err_r;
    logic [RD_LAT-1:0]       pipe_v_r;
    logic [RD_LAT-1:0][1:0]  pipe_off_r;

    logic [1:0] cur_off_s;
    logic       active_s;
    logic       abort_s;
    logic       issue_ok_s;
    logic       wr_go_s;
    logic       rd_go_s;
    logic       accept_s;
    logic       pend_s;

    // Access gating, abort detection and read-pipeline occupancy
    always_comb begin
        if (state_r == ST_WB) begin
            cur_off_s = wcnt_r;
        end else begin
            cur_off_s = rcnt_r;
        end
        active_s   = (state_r == ST_WB) || (state_r == ST_RD) || (state_r == ST_DRAIN);
        abort_s    = active_s && mem_err;
        issue_ok_s = !mem_stall && !mem_busy[cur_off_s] && !mem_err;
        wr_go_s    = (state_r == ST_WB) && issue_ok_s;
        rd_go_s    = (state_r == ST_RD) && issue_ok_s;
        accept_s   = (state_r == ST_IDLE) && req_valid && (req_wb || req_fill);
        // Only stages behind the tail matter: the tail returns in this cycle.
        pend_s = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pend_s = pend_s | pipe_v_r[i];
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s = req_wb ? ST_WB : ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (abort_s) begin
                    state_s = ST_FIN;
                end else if (wr_go_s && (wcnt_r == 2'd3)) begin
                    state_s = do_fill_r ? ST_RD : ST_FIN;
                end else begin
                    state_s = ST_WB;
                end
            end
            ST_RD: begin
                if (abort_s) begin
                    state_s = ST_FIN;
                end else if (rd_go_s && (rcnt_r == 2'd3)) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_DRAIN: begin
                if (abort_s || !pend_s) begin
                    state_s = ST_FIN;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FIN:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Per-transfer context: line addresses, fill flag, word counters, abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_line_r   <= '0;
            fill_line_r <= '0;
            do_fill_r   <= 1'b0;
            err_r       <= 1'b0;
            wcnt_r      <= 2'd0;
            rcnt_r      <= 2'd0;
        end else if (accept_s) begin
            wb_line_r   <= wb_line_addr;
            fill_line_r <= fill_line_addr;
            do_fill_r   <= req_fill;
            err_r       <= 1'b0;
            wcnt_r      <= 2'd0;
            rcnt_r      <= 2'd0;
        end else begin
            if (wr_go_s) wcnt_r <= wcnt_r + 2'd1;
            if (rd_go_s) rcnt_r <= rcnt_r + 2'd1;
            if (abort_s) err_r  <= 1'b1;
        end
    end

    // Read-return shift pipeline, flushed on reset or abort
    always_ff @(posedge clk) begin
        if (rst || abort_s) begin
            pipe_v_r   <= '0;
            pipe_off_r <= '0;
        end else begin
            pipe_v_r[0]   <= rd_go_s;
            pipe_off_r[0] <= rcnt_r;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_r[i]   <= pipe_v_r[i-1];
                pipe_off_r[i] <= pipe_off_r[i-1];
            end
        end
    end

    // Output decode; memory strobes follow the same-cycle gating inputs
    always_comb begin
        mem_wr       = wr_go_s;
        mem_rd       = rd_go_s;
        mem_addr     = '0;
        mem_data_out = '0;
        if (wr_go_s) begin
            mem_addr     = {wb_line_r, wcnt_r, 1'b0};
            mem_data_out = cache_rd_data;
        end else if (rd_go_s) begin
            mem_addr     = {fill_line_r, rcnt_r, 1'b0};
        end else begin
            mem_addr     = '0;
        end
        if (state_r == ST_WB) begin
            cache_rd_offset = wcnt_r;
        end else begin
            cache_rd_offset = 2'd0;
        end
        fill_valid = pipe_v_r[RD_LAT-1] && !abort_s;
        if (fill_valid) begin
            fill_offset = pipe_off_r[RD_LAT-1];
            fill_data   = mem_data_in;
        end else begin
            fill_offset = 2'd0;
            fill_data   = '0;
        end
        xfer_busy = (state_r != ST_IDLE);
        done      = (state_r == ST_FIN);
        err       = (state_r == ST_FIN) && err_r;
    end

endmodule

// File: doc/line_xfer_sequencer.md
Name: line_xfer_sequencer

Overview:
- Sits between the direct-mapped cache controller and the four-bank main memory.
- Turns a line-level request (dirty-line writeback, line fill, or both) into per-word memory accesses, throttled by memory bank-busy and stall.
- Returns fill words to the cache data array and signals completion with a one-cycle done pulse.
- The cache controller stalls while `xfer_busy` is high.

Parameters:
- DATA_W, 16, word width
- ADDR_W, 16, byte address width; line address = ADDR_W-3 bits (4 words x 2 bytes per line)
- RD_LAT, 2, cycles from `mem_rd` issue to valid `mem_data_in`

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request strobe, sampled only when xfer_busy=0
- req_wb  in  1  perform writeback of wb_line_addr
- req_fill  in  1  perform fill from fill_line_addr
- wb_line_addr  in  ADDR_W-3  line address of victim
- fill_line_addr  in  ADDR_W-3  line address of missing line
- cache_rd_offset  out  2  word index read from cache for writeback
- cache_rd_data  in  DATA_W  cache word at cache_rd_offset (combinational, same cycle)
- fill_valid  out  1  fill word valid this cycle
- fill_offset  out  2  word index of fill word
- fill_data  out  DATA_W  fill word
- xfer_busy  out  1  sequencer not idle
- done  out  1  one-cycle completion pulse
- err  out  1  asserted with done when the transfer aborted
- mem_addr  out  ADDR_W  word byte address {line, offset, 1'b0}
- mem_data_out  out  DATA_W  write data
- mem_wr  out  1  memory write
- mem_rd  out  1  memory read
- mem_data_in  in  DATA_W  read data
- mem_stall  in  1  memory cannot accept access
- mem_busy  in  4  per-bank busy; bank = mem_addr[2:1]
- mem_err  in  1  memory error

Behaviour:
- Reset: state IDLE; all outputs 0; word counters and read-return pipeline cleared. A reset during any transfer aborts it: no done, no further fill_valid, and in-flight read returns are discarded.
- States: IDLE, WB, RD, DRAIN, FIN.
- IDLE: accept when req_valid & (req_wb | req_fill).
  - Latch both line addresses and flags.
  - Go to WB if req_wb, else RD.
  - req_valid with neither flag set is ignored.
  - xfer_busy=0 only in IDLE.
- WB: word counter w = 0..3.
  - cache_rd_offset = w.
  - Issue condition: !mem_stall & !mem_busy[w].
  - When the condition holds: mem_wr=1, mem_addr = {wb_line, w, 0}, mem_data_out = cache_rd_data, then w increments.
  - Otherwise: mem_wr=0 and hold.
  - After w=3 issues, go to RD if req_fill, else FIN.
- RD: same issue gating; mem_rd=1, mem_addr = {fill_line, r, 0}, r = 0..3.
  - Each issue pushes {valid, r} into an RD_LAT-deep shift pipeline.
  - After r=3 issues, go to DRAIN.
- Read returns: the pipeline tail drives fill_valid and fill_offset; fill_data = mem_data_in. A read issued in cycle t produces fill_valid in cycle t+RD_LAT. The pipeline advances every cycle.
- DRAIN: wait until the pipeline is empty, then go to FIN.
- FIN: done=1 for one cycle, then IDLE. xfer_busy is still 1 during FIN.
- Errors: mem_err seen in WB/RD/DRAIN aborts.
  - Go to FIN with err=1 (err asserted only alongside done).
  - Pipeline is flushed and fill_valid is suppressed from the error cycle on.
- Never assert mem_wr and mem_rd in the same cycle; at most one access per cycle.
- Word counters are 2 bits; the transition is taken on the issue of word 3, with no wrap into a 5th access.
- Best-case latency, with accept in cycle 0:
  - Fill only: reads in cycles 1–4, fill_valid in cycles 3–6, done in cycle 7.
  - Writeback+fill: writes in cycles 1–4, reads in cycles 5–8 (subject to bank busy), done in cycle 11.
  - Writeback only: done in cycle 5.

Test Plan:
- Fill only, line 0x0123, memory words 0xA0..0xA3, no busy.
  - mem_rd at 0x0918/0x091A/0x091C/0x091E in cycles 1–4.
  - fill_valid in cycles 3–6, offsets 0..3, data 0xA0..0xA3.
  - done in cycle 7, err=0.
- Writeback+fill, wb line 0x0001, cache words 0x11,0x22,0x33,0x44, fill line 0x0002.
  - Writes to 0x0008..0x000E with those data.
  - Then reads of 0x0010..0x0016.
  - Exactly one done, no fill_valid during WB.
- Hold mem_busy[2]=1 for 3 cycles when word 2 is due.
  - mem_rd/mem_wr held low for exactly those 3 cycles, then word 2 issues.
  - done is delayed by 3 cycles versus the baseline; the word order is unchanged.
- Pulse mem_err in the cycle after the second read issues.
  - No further mem_rd, no further fill_valid.
  - Next cycle FIN: done=1 with err=1; then IDLE with xfer_busy=0.
- Assert rst in DRAIN with 2 reads in flight.
  - Next cycle all outputs are 0.
  - No fill_valid or done appears afterward.
  - A new fill request is accepted normally.
- req_valid with req_wb=req_fill=0, and req_valid pulsed while busy.
  - Both ignored: no memory access, no extra done.
